hdlc_tx_arbiter: RTL and testbench

- Frame-granular round-robin arbiter sharing one HDLC transmit byte stream between N requesters (per-channel frame sources).
- Sits between the channel frame buffers and the single bit-serial HDLC transmitter/framer.
- Grants one requester per frame, holds the grant until that frame's last byte, then enforces an inter-frame gap.
- Aborts over-length frames: signals the transmitter and drains the rest of the frame.

---
 rtl/hdlc_tx_arbiter_if.sv | 28 ++
 rtl/hdlc_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_hdlc_tx_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_tx_arbiter_if.sv
// Bundle between the per-channel frame sources, the arbiter and the HDLC transmitter.
// slave: the arbiter side. master: the sources plus the transmitter, as seen by a bench or wrapper.
interface hdlc_tx_arbiter_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0]   req;
    logic [8*N-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [7:0]     out_data;
    logic           out_valid;
    logic           out_last;
    logic           out_abort;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic           busy;

    modport slave (
        input  req, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_abort, grant, busy
    );

    modport master (
        output req, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_abort, grant, busy
    );
endinterface

// File: rtl/hdlc_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding one HDLC transmit byte stream.
// Holds a grant for a whole frame, enforces an inter-frame gap and aborts over-length frames.
module hdlc_tx_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned GAP       = 2,
    parameter int unsigned MAX_LEN   = 2048,
    parameter int unsigned LEN_ORDER = 12
) (
    input  logic              clk,
    input  logic              reset,
    hdlc_tx_arbiter_if.slave  bus
);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        GAPS  = 2'd3
    } state_e;

    state_e               state_q;
    logic [N-1:0]         grant_q;
    logic [PW-1:0]        owner_q;
    logic [PW-1:0]        ptr_q;
    logic [LEN_ORDER-1:0] count_q;
    logic [GW-1:0]        gap_q;
    logic                 abort_q;

    logic                 found_c;
    logic [PW-1:0]        pick_c;
    int unsigned          idx_c;
    logic [7:0]           sel_data_c;
    logic                 sel_valid_c;
    logic                 sel_last_c;
    logic [PW-1:0]        ptr_next_c;

    // Round-robin search starting at the pointer.
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        idx_c   = 0;
        for (int k = 0; k < int'(N); k++) begin
            idx_c = int'(ptr_q) + k;
            if (idx_c >= N) begin
                idx_c = idx_c - N;
            end
            if (!found_c && bus.req[PW'(idx_c)]) begin
                found_c = 1'b1;
                pick_c  = PW'(idx_c);
            end
        end
    end

    // Select the owner's byte lane.
    always_comb begin
        sel_data_c  = '0;
        sel_valid_c = 1'b0;
        sel_last_c  = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (owner_q == PW'(i)) begin
                sel_data_c  = bus.in_data[8*i +: 8];
                sel_valid_c = bus.in_valid[i];
                sel_last_c  = bus.in_last[i];
            end
        end
    end

    assign ptr_next_c = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);

    // Byte path is combinational so the transmitter sees the source without added latency.
    always_comb begin
        bus.in_ready  = '0;
        bus.out_data  = '0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        case (state_q)
            XFER: begin
                bus.out_data  = sel_data_c;
                bus.out_valid = sel_valid_c;
                bus.out_last  = sel_last_c;
                bus.in_ready  = grant_q & {N{bus.out_ready}};
            end
            DRAIN:   bus.in_ready = grant_q;
            default: ;
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.out_abort = abort_q;
    assign bus.busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            gap_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_c) begin
                        grant_q <= N'(1) << pick_c;
                        owner_q <= pick_c;
                        count_q <= '0;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (sel_valid_c && bus.out_ready) begin
                        if (count_q != '1) begin
                            count_q <= count_q + LEN_ORDER'(1);
                        end
                        if (sel_last_c) begin
                            grant_q <= '0;
                            ptr_q   <= ptr_next_c;
                            gap_q   <= '0;
                            state_q <= (GAP == 0) ? IDLE : GAPS;
                        end else if (count_q == LEN_ORDER'(MAX_LEN - 1)) begin
                            abort_q <= 1'b1;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Rest of an over-length frame is consumed and dropped.
                    if (sel_valid_c && sel_last_c) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_next_c;
                        gap_q   <= '0;
                        state_q <= (GAP == 0) ? IDLE : GAPS;
                    end
                end
                GAPS: begin
                    if (gap_q == GW'(int'(GAP) - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hdlc_tx_arbiter.sv
// Directed bench for hdlc_tx_arbiter (N=4, GAP=2, MAX_LEN=4): inputs change on the falling
// edge, checks run 1 ns later, and accepted bytes are captured on the rising edge.
module tb_hdlc_tx_arbiter;
    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       reset;
    int         total = 0;
    int         bad = 0;
    int         abort_cycles = 0;
    logic [7:0] captured[$];
    int         exp_ord[6];

    hdlc_tx_arbiter_if #(.N(N)) bus ();

    hdlc_tx_arbiter #(
        .N(N), .GAP(2), .MAX_LEN(4), .LEN_ORDER(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) captured.push_back(bus.out_data);
    end

    always @(negedge clk) begin
        if (bus.out_abort === 1'b1) abort_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [7:0] d, input logic v, input logic l);
        bus.in_data[8*i +: 8] = d;
        bus.in_valid[i]       = v;
        bus.in_last[i]        = l;
    endtask

    task automatic wait_grant(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 12 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (bus.grant !== '0) ok = 1'b1;
        end
        chk({tag, "_wait"}, 32'(ok), 32'd1);
    endtask

    // Sends one frame from requester i at one byte per cycle with out_ready held high.
    task automatic run_frame(input int i, input logic [7:0] base, input int len);
        @(negedge clk);
        bus.req[i] = 1'b1;
        set_src(i, base, 1'b1, (len == 1));
        wait_grant("frame");
        chk("frame_grant", 32'(bus.grant), 32'(1) << i);
        for (int k = 1; k < len; k++) begin
            @(negedge clk);
            set_src(i, base + 8'(k), 1'b1, (k == len - 1));
        end
        @(negedge clk);
        set_src(i, 8'h00, 1'b0, 1'b0);
        bus.req[i] = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.req       = '0;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_abort", 32'(bus.out_abort), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        captured.delete();

        // Single 3-byte frame from requester 2
        bus.out_ready = 1'b1;
        bus.req       = 4'b0100;
        set_src(2, 8'h11, 1'b1, 1'b0);
        #1 chk("t1_pre_grant", 32'(bus.grant), 32'd0);
        @(negedge clk); #1;
        chk("t1_grant", 32'(bus.grant), 32'h4);
        chk("t1_d0", 32'(bus.out_data), 32'h11);
        chk("t1_in_ready", 32'(bus.in_ready), 32'h4);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        @(negedge clk); set_src(2, 8'h22, 1'b1, 1'b0);
        #1 chk("t1_d1", 32'(bus.out_data), 32'h22);
        @(negedge clk); set_src(2, 8'h33, 1'b1, 1'b1);
        #1 chk("t1_d2", 32'(bus.out_data), 32'h33);
        chk("t1_last", 32'(bus.out_last), 32'd1);
        @(negedge clk); set_src(2, 8'h00, 1'b0, 1'b0); bus.req = 4'b1001;
        #1 chk("t1_gap0", 32'(bus.grant), 32'd0);
        chk("t1_gap_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_bytes", {8'h0, captured[0], captured[1], captured[2]}, 32'h00112233);
        chk("t1_count", 32'(captured.size()), 32'd3);
        @(negedge clk); #1 chk("t1_gap1", 32'(bus.grant), 32'd0);
        @(negedge clk); #1 chk("t1_idle_busy", 32'(bus.busy), 32'd0);
        chk("t1_idle_grant", 32'(bus.grant), 32'd0);
        @(negedge clk); #1 chk("t1_ptr", 32'(bus.grant), 32'h8);

        // Round-robin with 1-byte frames, requester 2 idle
        bus.req = 4'b1011;
        set_src(0, 8'hA0, 1'b1, 1'b1);
        set_src(1, 8'hA1, 1'b1, 1'b1);
        set_src(3, 8'hA3, 1'b1, 1'b1);
        exp_ord = '{3, 0, 1, 3, 0, 1};
        for (int k = 0; k < 6; k++) begin
            if (k > 0) wait_grant("rr");
            #1;
            chk("rr_grant", 32'(bus.grant), 32'(1) << exp_ord[k]);
            chk("rr_in_ready", 32'(bus.in_ready), 32'(1) << exp_ord[k]);
            chk("rr_data", 32'(bus.out_data), 32'(160 + exp_ord[k]));
            @(negedge clk); #1;
            chk("rr_released", 32'(bus.grant), 32'd0);
        end
        bus.req = '0;
        for (int i = 0; i < 4; i++) set_src(i, 8'h00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #1 chk("rr_idle", 32'(bus.busy), 32'd0);

        // Backpressure: 5 stalled cycles on byte 2 of a frame from requester 0
        captured.delete();
        @(negedge clk);
        bus.req = 4'b0001;
        set_src(0, 8'h51, 1'b1, 1'b0);
        wait_grant("bp");
        chk("bp_grant", 32'(bus.grant), 32'h1);
        chk("bp_d0", 32'(bus.out_data), 32'h51);
        @(negedge clk);
        set_src(0, 8'h52, 1'b1, 1'b0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_stall_data", 32'(bus.out_data), 32'h52);
            chk("bp_stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_stall_count", 32'(captured.size()), 32'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_resume_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk); set_src(0, 8'h53, 1'b1, 1'b1);
        @(negedge clk); set_src(0, 8'h00, 1'b0, 1'b0); bus.req = '0;
        #1 chk("bp_count", 32'(captured.size()), 32'd3);
        chk("bp_bytes", {8'h0, captured[0], captured[1], captured[2]}, 32'h00515253);
        repeat (3) @(negedge clk);

        // Over-length: 6 bytes from requester 1 with MAX_LEN=4, requester 2 waiting
        captured.delete();
        abort_cycles = 0;
        @(negedge clk);
        bus.req = 4'b0110;
        set_src(1, 8'h61, 1'b1, 1'b0);
        set_src(2, 8'h77, 1'b1, 1'b1);
        wait_grant("ol");
        chk("ol_grant", 32'(bus.grant), 32'h2);
        @(negedge clk); set_src(1, 8'h62, 1'b1, 1'b0);
        @(negedge clk); set_src(1, 8'h63, 1'b1, 1'b0);
        @(negedge clk); set_src(1, 8'h64, 1'b1, 1'b0);
        #1 chk("ol_no_abort_yet", 32'(bus.out_abort), 32'd0);
        chk("ol_d3", 32'(bus.out_data), 32'h64);
        @(negedge clk); set_src(1, 8'h65, 1'b1, 1'b0);
        #1 chk("ol_abort", 32'(bus.out_abort), 32'd1);
        chk("ol_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("ol_drain_ready", 32'(bus.in_ready), 32'h2);
        chk("ol_drain_grant", 32'(bus.grant), 32'h2);
        chk("ol_sent", 32'(captured.size()), 32'd4);
        @(negedge clk); set_src(1, 8'h66, 1'b1, 1'b1);
        #1 chk("ol_abort_end", 32'(bus.out_abort), 32'd0);
        chk("ol_drain_valid2", 32'(bus.out_valid), 32'd0);
        @(negedge clk); set_src(1, 8'h00, 1'b0, 1'b0); bus.req = 4'b0100;
        #1 chk("ol_gap", 32'(bus.grant), 32'd0);
        chk("ol_count", 32'(captured.size()), 32'd4);
        chk("ol_bytes", {captured[0], captured[1], captured[2], captured[3]}, 32'h61626364);
        chk("ol_abort_cycles", 32'(abort_cycles), 32'd1);
        wait_grant("ol_next");
        chk("ol_next_grant", 32'(bus.grant), 32'h4);
        chk("ol_next_data", 32'(bus.out_data), 32'h77);
        @(negedge clk); set_src(2, 8'h00, 1'b0, 1'b0); bus.req = '0;
        repeat (3) @(negedge clk);

        // Exact-length frame of MAX_LEN bytes from requester 3
        captured.delete();
        abort_cycles = 0;
        run_frame(3, 8'h81, 4);
        #1 chk("ex_gap", 32'(bus.grant), 32'd0);
        repeat (3) @(negedge clk);
        #1 chk("ex_count", 32'(captured.size()), 32'd4);
        chk("ex_bytes", {captured[0], captured[1], captured[2], captured[3]}, 32'h81828384);
        chk("ex_abort", 32'(abort_cycles), 32'd0);
        chk("ex_idle", 32'(bus.busy), 32'd0);

        // Reset mid-frame, with the pointer left at 1 beforehand
        run_frame(0, 8'hC0, 1);
        repeat (3) @(negedge clk);
        abort_cycles = 0;
        @(negedge clk);
        bus.req = 4'b0100;
        set_src(2, 8'h91, 1'b1, 1'b0);
        wait_grant("rs");
        chk("rs_grant", 32'(bus.grant), 32'h4);
        @(negedge clk); set_src(2, 8'h92, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 chk("rs_grant_clr", 32'(bus.grant), 32'd0);
        chk("rs_valid", 32'(bus.out_valid), 32'd0);
        chk("rs_busy", 32'(bus.busy), 32'd0);
        chk("rs_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rs_abort", 32'(bus.out_abort), 32'd0);
        @(negedge clk); #1;
        chk("rs_abort_cycles", 32'(abort_cycles), 32'd0);
        set_src(2, 8'h00, 1'b0, 1'b0);
        set_src(0, 8'hD0, 1'b1, 1'b1);
        bus.req = 4'b0101;
        reset   = 1'b0;
        wait_grant("rs_after");
        chk("rs_after_grant", 32'(bus.grant), 32'h1);
        chk("rs_after_data", 32'(bus.out_data), 32'hD0);
        @(negedge clk); set_src(0, 8'h00, 1'b0, 1'b0); bus.req = '0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
